// File: rtl/ro_power_sched_if.sv
// Trigger/config/enable bundle between the burst controller and the ring-oscillator bank.
interface ro_power_sched_if #(
  parameter int NUM_RO  = 8,
  parameter int CNT_W   = 16,
  parameter int CNT_N_W = $clog2(NUM_RO + 1)
);
  logic               arm;
  logic               trigger;
  logic               abort;
  logic [CNT_N_W-1:0] cfg_num_active;
  logic [CNT_W-1:0]   cfg_ramp_cycles;
  logic [CNT_W-1:0]   cfg_on_cycles;
  logic [CNT_W-1:0]   cfg_off_cycles;
  logic [7:0]         cfg_bursts;
  logic [NUM_RO-1:0]  ro_en;
  logic [CNT_N_W-1:0] active_count;
  logic               busy;
  logic               done;

  modport master (
    output arm, trigger, abort, cfg_num_active, cfg_ramp_cycles,
           cfg_on_cycles, cfg_off_cycles, cfg_bursts,
    input  ro_en, active_count, busy, done
  );

  modport slave (
    input  arm, trigger, abort, cfg_num_active, cfg_ramp_cycles,
           cfg_on_cycles, cfg_off_cycles, cfg_bursts,
    output ro_en, active_count, busy, done
  );
endinterface

// File: rtl/ro_power_sched.sv
// Thermometer ramp-up / hold / ramp-down / idle burst sequencer for a ring-oscillator load bank.
// States: IDLE wait trigger | RAMP_UP add bit per R | ON hold | RAMP_DOWN drop bit per R | OFF gap
module ro_power_sched #(
  parameter int NUM_RO  = 8,
  parameter int CNT_W   = 16,
  parameter int CNT_N_W = $clog2(NUM_RO + 1)
) (
  input logic               clk,
  input logic               rst_n,
  ro_power_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_ON,
    S_RAMP_DOWN,
    S_OFF
  } state_t;

  localparam logic [CNT_N_W-1:0] N_MAX = CNT_N_W'(NUM_RO);
  localparam logic [CNT_N_W-1:0] N_ONE = CNT_N_W'(1);

  state_t             state_q, state_d;
  logic [CNT_N_W-1:0] cnt_q, cnt_d;
  logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [7:0]         burst_q, burst_d;
  logic               done_q, done_d;
  logic               arm_q;
  logic [CNT_N_W-1:0] n_q, n_d;
  logic [CNT_W-1:0]   ramp_ld_q, ramp_ld_d;
  logic [CNT_W-1:0]   on_ld_q, on_ld_d;
  logic [CNT_W-1:0]   off_ld_q, off_ld_d;
  logic [7:0]         bursts_q, bursts_d;

  logic [CNT_N_W-1:0] cap_n;
  logic [CNT_W-1:0]   cap_ramp, cap_on, cap_off;
  logic               tmr_done;

  // Timer reload values are duration-1, with a programmed 0 behaving like 1.
  assign cap_n    = (bus.cfg_num_active > N_MAX) ? N_MAX : bus.cfg_num_active;
  assign cap_ramp = (bus.cfg_ramp_cycles == '0) ? '0 : bus.cfg_ramp_cycles - CNT_W'(1);
  assign cap_on   = (bus.cfg_on_cycles   == '0) ? '0 : bus.cfg_on_cycles   - CNT_W'(1);
  assign cap_off  = (bus.cfg_off_cycles  == '0) ? '0 : bus.cfg_off_cycles  - CNT_W'(1);
  assign tmr_done = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ro_en_q   <= '0;
      timer_q   <= '0;
      burst_q   <= '0;
      done_q    <= 1'b0;
      arm_q     <= 1'b0;
      n_q       <= '0;
      ramp_ld_q <= '0;
      on_ld_q   <= '0;
      off_ld_q  <= '0;
      bursts_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ro_en_q   <= ro_en_d;
      timer_q   <= timer_d;
      burst_q   <= burst_d;
      done_q    <= done_d;
      arm_q     <= bus.arm;
      n_q       <= n_d;
      ramp_ld_q <= ramp_ld_d;
      on_ld_q   <= on_ld_d;
      off_ld_q  <= off_ld_d;
      bursts_q  <= bursts_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = tmr_done ? '0 : timer_q - CNT_W'(1);
    burst_d   = burst_q;
    done_d    = 1'b0;
    n_d       = n_q;
    ramp_ld_d = ramp_ld_q;
    on_ld_d   = on_ld_q;
    off_ld_d  = off_ld_q;
    bursts_d  = bursts_q;

    case (state_q)
      S_IDLE: begin
        if (bus.trigger && bus.arm) begin
          n_d       = cap_n;
          ramp_ld_d = cap_ramp;
          on_ld_d   = cap_on;
          off_ld_d  = cap_off;
          bursts_d  = bus.cfg_bursts;
          burst_d   = '0;
          if (cap_n == '0) begin
            done_d = 1'b1;
          end else begin
            cnt_d = N_ONE;
            if (cap_n == N_ONE) begin
              state_d = S_ON;
              timer_d = cap_on;
            end else begin
              state_d = S_RAMP_UP;
              timer_d = cap_ramp;
            end
          end
        end
      end
      S_RAMP_UP: begin
        if (!bus.arm) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = cnt_q - N_ONE;
          timer_d = ramp_ld_q;
        end else if (tmr_done) begin
          cnt_d = cnt_q + N_ONE;
          if ((cnt_q + N_ONE) == n_q) begin
            state_d = S_ON;
            timer_d = on_ld_q;
          end else begin
            timer_d = ramp_ld_q;
          end
        end
      end
      S_ON: begin
        if (!bus.arm || tmr_done) begin
          state_d = S_RAMP_DOWN;
          cnt_d   = cnt_q - N_ONE;
          timer_d = ramp_ld_q;
        end
      end
      S_RAMP_DOWN: begin
        // A single-oscillator burst arrives here already at zero and still spends one R step.
        if (tmr_done) begin
          if (cnt_q <= N_ONE) begin
            state_d = S_OFF;
            cnt_d   = '0;
            timer_d = off_ld_q;
            if ((bursts_q != '0) && (burst_q != 8'hFF))
              burst_d = burst_q + 8'd1;
          end else begin
            cnt_d   = cnt_q - N_ONE;
            timer_d = ramp_ld_q;
          end
        end
      end
      S_OFF: begin
        // Only a fresh arm fall cuts the gap short; arm already low lets the gap run out.
        if (arm_q && !bus.arm) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tmr_done) begin
          if (bus.arm && ((bursts_q == '0) || (burst_q < bursts_q))) begin
            cnt_d = N_ONE;
            if (n_q == N_ONE) begin
              state_d = S_ON;
              timer_d = on_ld_q;
            end else begin
              state_d = S_RAMP_UP;
              timer_d = ramp_ld_q;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      timer_d = '0;
      done_d  = 1'b0;
    end

    for (int i = 0; i < NUM_RO; i++)
      ro_en_d[i] = (CNT_N_W'(i) < cnt_d);
  end

  assign bus.ro_en        = ro_en_q;
  assign bus.active_count = cnt_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_ro_power_sched.sv
// Directed bench for ro_power_sched: single/multi burst, clamping, abort, arm drop, async reset.
module tb_ro_power_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  ro_power_sched_if #(.NUM_RO(8), .CNT_W(16)) bus ();

  ro_power_sched #(.NUM_RO(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int k);
    while (e < k) begin
      @(posedge clk);
      e++;
      #1;
    end
  endtask

  task automatic fire();
    bus.trigger = 1'b1;
    @(posedge clk);
    #1;
    bus.trigger = 1'b0;
    e = 0;
  endtask

  task automatic cfg(input int n, input int r, input int ton, input int toff, input int b);
    bus.cfg_num_active  = 4'(n);
    bus.cfg_ramp_cycles = 16'(r);
    bus.cfg_on_cycles   = 16'(ton);
    bus.cfg_off_cycles  = 16'(toff);
    bus.cfg_bursts      = 8'(b);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] exp_en;
    logic       exp_done;
    rst_n       = 1'b0;
    bus.arm     = 1'b0;
    bus.trigger = 1'b0;
    bus.abort   = 1'b0;
    cfg(0, 0, 0, 0, 0);
    #3;
    check("rst_ro_en", bus.ro_en, 8'h00);
    check("rst_count", bus.active_count, 4'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single burst; config changes and a trigger while busy must be ignored.
    bus.arm = 1'b1;
    cfg(2, 3, 4, 2, 1);
    fire();
    check("sb_e0_en", bus.ro_en, 8'h01);
    check("sb_e0_busy", bus.busy, 1'b1);
    goto(1);
    cfg(5, 1, 1, 1, 1);
    goto(2);
    check("sb_e2_en", bus.ro_en, 8'h01);
    goto(3);
    check("sb_e3_en", bus.ro_en, 8'h03);
    check("sb_e3_cnt", bus.active_count, 4'd2);
    goto(5);
    bus.trigger = 1'b1;
    goto(6);
    bus.trigger = 1'b0;
    check("sb_e6_en", bus.ro_en, 8'h03);
    goto(7);
    check("sb_e7_en", bus.ro_en, 8'h01);
    goto(10);
    check("sb_e10_en", bus.ro_en, 8'h00);
    check("sb_e10_busy", bus.busy, 1'b1);
    goto(11);
    check("sb_e11_done", bus.done, 1'b0);
    goto(12);
    check("sb_e12_done", bus.done, 1'b1);
    check("sb_e12_busy", bus.busy, 1'b0);
    goto(13);
    check("sb_e13_done", bus.done, 1'b0);
    check("sb_e13_busy", bus.busy, 1'b0);
    gap(2);

    // Clamp 15 -> 8 with zero ramp/on/off treated as 1.
    cfg(15, 0, 0, 0, 1);
    fire();
    for (int k = 0; k <= 16; k++) begin
      goto(k);
      if (k <= 7) exp_en = 8'((1 << (k + 1)) - 1);
      else        exp_en = 8'hFF >> (k - 7);
      exp_done = (k == 16);
      check($sformatf("clamp_e%0d", k), {bus.done, bus.ro_en}, {exp_done, exp_en});
    end
    gap(2);

    // N = 0: immediate done, no enables.
    cfg(0, 3, 3, 3, 1);
    fire();
    check("n0_done", bus.done, 1'b1);
    check("n0_en", bus.ro_en, 8'h00);
    check("n0_busy", bus.busy, 1'b0);
    goto(1);
    check("n0_done_clr", bus.done, 1'b0);
    gap(2);

    // Three bursts of one oscillator: windows at 0, 8, 16; done at 24.
    cfg(1, 1, 2, 5, 3);
    fire();
    for (int k = 0; k <= 27; k++) begin
      goto(k);
      exp_en   = ((k < 24) && ((k % 8) < 2)) ? 8'h01 : 8'h00;
      exp_done = (k == 24);
      check($sformatf("mb_e%0d", k), {bus.busy, bus.done, bus.ro_en},
            {(k < 24), exp_done, exp_en});
    end
    gap(2);

    // Abort during ON at 0x0F.
    cfg(4, 1, 10, 1, 1);
    fire();
    goto(5);
    check("ab_on_en", bus.ro_en, 8'h0F);
    bus.abort = 1'b1;
    goto(6);
    check("ab_en", bus.ro_en, 8'h00);
    check("ab_cnt", bus.active_count, 4'd0);
    check("ab_busy", bus.busy, 1'b0);
    check("ab_done", bus.done, 1'b0);
    bus.abort = 1'b0;
    goto(7);
    check("ab_done_late", bus.done, 1'b0);
    bus.abort = 1'b1;
    fire();
    check("ab_trig_busy", bus.busy, 1'b0);
    check("ab_trig_en", bus.ro_en, 8'h00);
    check("ab_trig_done", bus.done, 1'b0);
    bus.abort = 1'b0;
    gap(2);

    // Arm drop in RAMP_UP at count 3 with infinite bursts.
    cfg(5, 2, 3, 3, 0);
    fire();
    goto(4);
    check("ad_e4_cnt", bus.active_count, 4'd3);
    bus.arm = 1'b0;
    goto(5);
    check("ad_e5_cnt", bus.active_count, 4'd2);
    goto(6);
    check("ad_e6_cnt", bus.active_count, 4'd2);
    goto(7);
    check("ad_e7_en", bus.ro_en, 8'h01);
    goto(9);
    check("ad_e9_en", bus.ro_en, 8'h00);
    check("ad_e9_busy", bus.busy, 1'b1);
    goto(11);
    check("ad_e11_done", {bus.busy, bus.done}, 2'b10);
    goto(12);
    check("ad_e12_done", {bus.busy, bus.done}, 2'b01);
    bus.arm = 1'b1;
    gap(2);

    // Asynchronous reset between edges while ON.
    cfg(4, 1, 20, 1, 1);
    fire();
    goto(5);
    check("ar_on_en", bus.ro_en, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_en", bus.ro_en, 8'h00);
    check("ar_busy", bus.busy, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg(2, 1, 1, 1, 1);
    fire();
    check("ar_re_en", bus.ro_en, 8'h01);
    check("ar_re_busy", bus.busy, 1'b1);
    goto(1);
    check("ar_re_e1_en", bus.ro_en, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
